// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection of up to NUM_PORTS requesters per
// cycle onto registered broadcast ports, with a per-tag completion vector.
module cdb_arbiter #(
   parameter int NUM_REQ   = 5,
   parameter int NUM_PORTS = 2,
   parameter int TAG_W     = 3,
   parameter int DATA_W    = 32
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          flush_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*TAG_W-1:0]      req_tag_i,
   input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic [NUM_PORTS-1:0]          bcast_valid_o,
   output logic [NUM_PORTS*TAG_W-1:0]    bcast_tag_o,
   output logic [NUM_PORTS*DATA_W-1:0]   bcast_data_o,
   output logic [(2**TAG_W)-1:0]         tag_done_o,
   output logic                          dup_tag_err_o
);

   localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W    = $clog2(NUM_PORTS + 1);
   localparam int NUM_TAGS = 2**TAG_W;

   logic [TAG_W-1:0]    tag_arr  [NUM_REQ];
   logic [DATA_W-1:0]   data_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign tag_arr[gi]  = req_tag_i[gi*TAG_W +: TAG_W];
         assign data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];
      end
   endgenerate

   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]  grant;
   logic [PTR_W-1:0]    sel_idx [NUM_PORTS];
   logic [NUM_PORTS-1:0] sel_vld;
   logic [CNT_W-1:0]    port_cnt;
   logic [PTR_W:0]      scan_sum;
   logic [PTR_W-1:0]    scan_idx;
   logic [PTR_W-1:0]    last_idx;
   logic                tag_hit;
   logic                dup_hit;
   logic                scan_en;

   // Priority scan starting at rr_ptr_q, wrapping at NUM_REQ; duplicate-tag losers
   // are skipped without consuming a port.
   always_comb begin
      scan_en  = reset_n_i & ~flush_i;
      grant    = '0;
      sel_vld  = '0;
      port_cnt = '0;
      dup_hit  = 1'b0;
      last_idx = rr_ptr_q;
      scan_sum = '0;
      scan_idx = '0;
      tag_hit  = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         sel_idx[p] = '0;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
         end
         scan_idx = scan_sum[PTR_W-1:0];
         if (scan_en && req_valid_i[scan_idx] && (port_cnt < CNT_W'(NUM_PORTS))) begin
            tag_hit = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
               if (grant[j] && (tag_arr[j] == tag_arr[scan_idx])) begin
                  tag_hit = 1'b1;
               end
            end
            if (tag_hit) begin
               dup_hit = 1'b1;
            end else begin
               grant[scan_idx] = 1'b1;
               for (int p = 0; p < NUM_PORTS; p++) begin
                  if (CNT_W'(p) == port_cnt) begin
                     sel_vld[p] = 1'b1;
                     sel_idx[p] = scan_idx;
                  end
               end
               port_cnt = port_cnt + CNT_W'(1);
               last_idx = scan_idx;
            end
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (port_cnt != '0) begin
         rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
      end
   end

   assign req_ready_o = grant;

   logic [NUM_PORTS-1:0] bcast_valid_q, bcast_valid_d;
   logic [TAG_W-1:0]     bcast_tag_q  [NUM_PORTS];
   logic [TAG_W-1:0]     bcast_tag_d  [NUM_PORTS];
   logic [DATA_W-1:0]    bcast_data_q [NUM_PORTS];
   logic [DATA_W-1:0]    bcast_data_d [NUM_PORTS];
   logic [NUM_TAGS-1:0]  tag_done_q, tag_done_d;
   logic                 dup_tag_err_q, dup_tag_err_d;

   always_comb begin
      bcast_valid_d = sel_vld;
      tag_done_d    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         bcast_tag_d[p]  = sel_vld[p] ? tag_arr[sel_idx[p]]  : '0;
         bcast_data_d[p] = sel_vld[p] ? data_arr[sel_idx[p]] : '0;
         if (sel_vld[p]) begin
            tag_done_d[tag_arr[sel_idx[p]]] = 1'b1;
         end
      end
      dup_tag_err_d = dup_tag_err_q | dup_hit;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rr_ptr_q      <= '0;
         bcast_valid_q <= '0;
         tag_done_q    <= '0;
         dup_tag_err_q <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            bcast_tag_q[p]  <= '0;
            bcast_data_q[p] <= '0;
         end
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         bcast_valid_q <= bcast_valid_d;
         tag_done_q    <= tag_done_d;
         dup_tag_err_q <= dup_tag_err_d;
         for (int p = 0; p < NUM_PORTS; p++) begin
            bcast_tag_q[p]  <= bcast_tag_d[p];
            bcast_data_q[p] <= bcast_data_d[p];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_pack
         assign bcast_tag_o[gi*TAG_W +: TAG_W]    = bcast_tag_q[gi];
         assign bcast_data_o[gi*DATA_W +: DATA_W] = bcast_data_q[gi];
      end
   endgenerate

   assign bcast_valid_o = bcast_valid_q;
   assign tag_done_o    = tag_done_q;
   assign dup_tag_err_o = dup_tag_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based model of the
// round-robin grant rules.
module tb_cdb_arbiter;

   localparam int NR = 5;
   localparam int NP = 2;
   localparam int TW = 3;
   localparam int DW = 32;

   logic               clk = 1'b0;
   logic               reset_n = 1'b1;
   logic               flush = 1'b0;
   logic [NR-1:0]      req_valid = '0;
   logic [NR*TW-1:0]   req_tag = '0;
   logic [NR*DW-1:0]   req_data = '0;
   logic [NR-1:0]      req_ready;
   logic [NP-1:0]      bcast_valid;
   logic [NP*TW-1:0]   bcast_tag;
   logic [NP*DW-1:0]   bcast_data;
   logic [(2**TW)-1:0] tag_done;
   logic               dup_tag_err;

   cdb_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .TAG_W(TW), .DATA_W(DW)) dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .flush_i       (flush),
      .req_valid_i   (req_valid),
      .req_tag_i     (req_tag),
      .req_data_i    (req_data),
      .req_ready_o   (req_ready),
      .bcast_valid_o (bcast_valid),
      .bcast_tag_o   (bcast_tag),
      .bcast_data_o  (bcast_data),
      .tag_done_o    (tag_done),
      .dup_tag_err_o (dup_tag_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check_val(input string what, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", what, got, exp, cyc);
      end
   endtask

   // Requester state as the bench sees it
   bit [NR-1:0] v_val;
   bit [TW-1:0] v_tag  [NR];
   bit [DW-1:0] v_data [NR];

   // Reference model state
   int           m_rr  = 0;
   bit           m_dup = 1'b0;
   bit           m_dupnow;
   int           m_sel[$];
   bit [NR-1:0]  exp_rdy;
   bit [NP-1:0]  exp_bv;
   bit [NP*TW-1:0] exp_bt;
   bit [NP*DW-1:0] exp_bd;
   bit [(2**TW)-1:0] exp_td;

   // Visit requesters in priority order; the first NP valid ones with a fresh tag win.
   function automatic void model_scan();
      int  i;
      bit  seen;
      m_sel.delete();
      m_dupnow = 1'b0;
      if (reset_n && !flush) begin
         for (int k = 0; k < NR; k++) begin
            i = (m_rr + k) % NR;
            if (v_val[i] && m_sel.size() < NP) begin
               seen = 1'b0;
               foreach (m_sel[s]) if (v_tag[m_sel[s]] == v_tag[i]) seen = 1'b1;
               if (seen) m_dupnow = 1'b1;
               else m_sel.push_back(i);
            end
         end
      end
      exp_rdy = '0;
      foreach (m_sel[s]) exp_rdy[m_sel[s]] = 1'b1;
   endfunction

   function automatic void model_edge();
      exp_bv = '0;
      exp_bt = '0;
      exp_bd = '0;
      exp_td = '0;
      foreach (m_sel[s]) begin
         exp_bv[s] = 1'b1;
         exp_bt[s*TW +: TW] = v_tag[m_sel[s]];
         exp_bd[s*DW +: DW] = v_data[m_sel[s]];
         exp_td[v_tag[m_sel[s]]] = 1'b1;
      end
      if (m_dupnow) m_dup = 1'b1;
      if (m_sel.size() > 0) m_rr = (m_sel[m_sel.size()-1] + 1) % NR;
   endfunction

   task automatic step(input bit fl);
      flush = fl;
      req_valid = v_val;
      for (int i = 0; i < NR; i++) begin
         req_tag[i*TW +: TW]  = v_tag[i];
         req_data[i*DW +: DW] = v_data[i];
      end
      #1;
      model_scan();
      check_val("req_ready", 64'(req_ready), 64'(exp_rdy));
      @(posedge clk);
      model_edge();
      #2;
      cyc++;
      check_val("bcast_valid", 64'(bcast_valid), 64'(exp_bv));
      check_val("bcast_tag", 64'(bcast_tag), 64'(exp_bt));
      check_val("bcast_data", 64'(bcast_data), 64'(exp_bd));
      check_val("tag_done", 64'(tag_done), 64'(exp_td));
      check_val("dup_tag_err", 64'(dup_tag_err), 64'(m_dup));
      $display("cyc %0d v=%b fl=%0d rdy=%b bv=%b bt=%h td=%h dup=%0d",
               cyc, v_val, fl, req_ready, bcast_valid, bcast_tag, tag_done, dup_tag_err);
   endtask

   // Asynchronous reset: outputs must clear before any further clock edge.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check_val("rst_ready", 64'(req_ready), 64'd0);
      check_val("rst_bvalid", 64'(bcast_valid), 64'd0);
      check_val("rst_btag", 64'(bcast_tag), 64'd0);
      check_val("rst_bdata", 64'(bcast_data), 64'd0);
      check_val("rst_tagdone", 64'(tag_done), 64'd0);
      check_val("rst_dup", 64'(dup_tag_err), 64'd0);
      m_rr  = 0;
      m_dup = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      $display("reset pulse done at cycle %0d", cyc);
   endtask

   task automatic set_req(input int i, input bit [TW-1:0] t, input bit [DW-1:0] d);
      v_tag[i]  = t;
      v_data[i] = d;
   endtask

   initial begin
      for (int i = 0; i < NR; i++) set_req(i, TW'(i), 32'h1111_1111 * i);
      v_val = '1;
      req_valid = '1;
      @(posedge clk);
      #2;

      // Reset with every requester valid, then contention from rr_ptr=0
      do_reset();
      step(1'b0);
      check_val("ctn1_ready_seen", 64'(bcast_valid), 64'h3);
      check_val("ctn1_td", 64'(tag_done), 64'h03);
      v_val = 5'b11100;
      step(1'b0);
      check_val("ctn2_td", 64'(tag_done), 64'h0C);
      v_val = 5'b10000;
      step(1'b0);
      check_val("ctn3_td", 64'(tag_done), 64'h10);
      check_val("ctn3_bv", 64'(bcast_valid), 64'h1);
      v_val = '0;
      step(1'b0);
      check_val("idle_bv", 64'(bcast_valid), 64'h0);

      // Single request
      v_val = 5'b00100;
      set_req(2, 3'd5, 32'hDEAD_BEEF);
      step(1'b0);
      check_val("single_bv", 64'(bcast_valid), 64'h1);
      check_val("single_tag", 64'(bcast_tag[TW-1:0]), 64'd5);
      check_val("single_data", 64'(bcast_data[DW-1:0]), 64'hDEAD_BEEF);
      check_val("single_td", 64'(tag_done), 64'h20);
      v_val = '0;
      step(1'b0);
      check_val("single_after_td", 64'(tag_done), 64'h0);

      // Bring rr_ptr to 4, then check wrap priority
      v_val = 5'b01000;
      set_req(3, 3'd0, 32'h3333_0000);
      step(1'b0);
      v_val = 5'b10001;
      set_req(0, 3'd1, 32'hA0A0_0000);
      set_req(4, 3'd2, 32'hA4A4_0000);
      step(1'b0);
      check_val("wrap_tags", 64'(bcast_tag), 64'(6'b001_010));
      check_val("wrap_data0", 64'(bcast_data[DW-1:0]), 64'hA4A4_0000);

      // Bring rr_ptr to 0, then a duplicate tag
      v_val = 5'b10000;
      set_req(4, 3'd3, 32'h4444_0000);
      step(1'b0);
      check_val("dup_before", 64'(dup_tag_err), 64'd0);
      v_val = 5'b01001;
      set_req(0, 3'd6, 32'h0000_0006);
      set_req(3, 3'd6, 32'h3333_0006);
      step(1'b0);
      check_val("dup_bv", 64'(bcast_valid), 64'h1);
      check_val("dup_set", 64'(dup_tag_err), 64'd1);
      v_val = 5'b01000;
      step(1'b0);
      check_val("dup_loser_data", 64'(bcast_data[DW-1:0]), 64'h3333_0006);
      v_val = '0;
      repeat (10) step(1'b0);
      check_val("dup_sticky", 64'(dup_tag_err), 64'd1);

      // Flush with everything valid, then reset in the middle of a broadcast
      for (int i = 0; i < NR; i++) set_req(i, TW'(i), 32'h5555_0000 + i);
      v_val = '1;
      step(1'b1);
      check_val("flush_bv", 64'(bcast_valid), 64'h0);
      step(1'b0);
      check_val("postflush_tags", 64'(bcast_tag), 64'(6'b000_100));
      do_reset();

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         bit [NR-1:0] g;
         g = exp_rdy;
         for (int i = 0; i < NR; i++) begin
            if (g[i] || !v_val[i]) begin
               v_val[i] = ($urandom_range(0, 1) == 1);
               set_req(i, TW'($urandom_range(0, 7)), $urandom);
            end else if ($urandom_range(0, 15) == 0) begin
               v_val[i] = 1'b0;
            end
         end
         if ($urandom_range(0, 299) == 0) do_reset();
         step($urandom_range(0, 19) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
